// File: rtl/multi_debouncer.sv
// ---------------------------------------------------------------------------
// multi_debouncer
//
// Purpose:
//    CH independent switch debouncers. Each channel accepts a new level only
//    after its input has held that level for STABLE_CNT enabled cycles. A
//    bounce back to the accepted level abandons the qualification, and the
//    next attempt starts again from zero. The en strobe gates the counting
//    only; aborts happen whether or not en is high.
//
// Ports:
//    clk          in   1    clock; all state changes on the rising edge
//    rst          in   1    asynchronous reset, active low
//    en           in   1    count strobe; counters advance only when high
//    noisy_in     in   CH   raw switch levels, one bit per channel
//    debounce_out out  CH   accepted stable level per channel
//    rise_pulse   out  CH   one-cycle pulse when debounce_out goes 0->1
//    fall_pulse   out  CH   one-cycle pulse when debounce_out goes 1->0
//    busy         out  1    some channel is qualifying a level change
//
// Parameters:
//    CH           number of channels (1..32)
//    CNT_W        width of each channel's stability counter
//    STABLE_CNT   qualifying cycles needed (1..2^CNT_W-1)
//
// Build option:
//    DEBOUNCE_SYNC_EN  when defined, each noisy_in bit passes through a
//                      2-flop synchronizer (reset to 0) before the FSM. Every
//                      latency grows by 2 cycles. When undefined, the FSM
//                      samples noisy_in directly, so the caller must supply
//                      inputs that are already synchronous to clk.
// ---------------------------------------------------------------------------
module multi_debouncer #(
   parameter int CH         = 4,
   parameter int CNT_W      = 16,
   parameter int STABLE_CNT = 1000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic [CH-1:0] noisy_in,
   output logic [CH-1:0] debounce_out,
   output logic [CH-1:0] rise_pulse,
   output logic [CH-1:0] fall_pulse,
   output logic          busy
);

   // The top bit of the encoding is the accepted level, and the low bit is
   // the in-qualification flag.
   typedef enum logic [1:0] {
      LOW     = 2'b00,
      WAIT_HI = 2'b01,
      HIGH    = 2'b10,
      WAIT_LO = 2'b11
   } state_t;

   // When this count is reached on an enabled cycle, qualification completes.
   // Qualification stops there, so the counter never wraps.
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CNT - 1);

   logic [CH-1:0] s_in;
   logic [CH-1:0] wait_vec;

`ifdef DEBOUNCE_SYNC_EN
   logic [CH-1:0] sync1_reg;
   logic [CH-1:0] sync2_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_reg <= '0;
         sync2_reg <= '0;
      end else begin
         sync1_reg <= noisy_in;
         sync2_reg <= sync1_reg;
      end
   end

   assign s_in = sync2_reg;
`else
   assign s_in = noisy_in;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < CH; gi++) begin : g_ch
         state_t           state_reg, state_next;
         logic [CNT_W-1:0] cnt_reg, cnt_next;
         logic             rise_reg, rise_next;
         logic             fall_reg, fall_next;

         always_comb begin
            state_next = state_reg;
            cnt_next   = cnt_reg;
            rise_next  = 1'b0;
            fall_next  = 1'b0;
            case (state_reg)
               LOW: begin
                  if (s_in[gi]) begin
                     state_next = WAIT_HI;
                     cnt_next   = '0;
                  end
               end
               WAIT_HI: begin
                  if (!s_in[gi]) begin
                     state_next = LOW;
                     cnt_next   = '0;
                  end else if (en) begin
                     if (cnt_reg == LAST_CNT) begin
                        state_next = HIGH;
                        cnt_next   = '0;
                        rise_next  = 1'b1;
                     end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                     end
                  end
               end
               HIGH: begin
                  if (!s_in[gi]) begin
                     state_next = WAIT_LO;
                     cnt_next   = '0;
                  end
               end
               WAIT_LO: begin
                  if (s_in[gi]) begin
                     state_next = HIGH;
                     cnt_next   = '0;
                  end else if (en) begin
                     if (cnt_reg == LAST_CNT) begin
                        state_next = LOW;
                        cnt_next   = '0;
                        fall_next  = 1'b1;
                     end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                     end
                  end
               end
               default: begin
                  state_next = LOW;
                  cnt_next   = '0;
               end
            endcase
         end

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               state_reg <= LOW;
               cnt_reg   <= '0;
               rise_reg  <= 1'b0;
               fall_reg  <= 1'b0;
            end else begin
               state_reg <= state_next;
               cnt_reg   <= cnt_next;
               rise_reg  <= rise_next;
               fall_reg  <= fall_next;
            end
         end

         // The pulse register loads on the same edge as the state change.
         // The pulse therefore appears in the first cycle that shows the new
         // level.
         assign debounce_out[gi] = (state_reg == HIGH) || (state_reg == WAIT_LO);
         assign wait_vec[gi]     = (state_reg == WAIT_HI) || (state_reg == WAIT_LO);
         assign rise_pulse[gi]   = rise_reg;
         assign fall_pulse[gi]   = fall_reg;
      end
   endgenerate

   assign busy = |wait_vec;

endmodule

// File: doc/multi_debouncer.md
MULTI_DEBOUNCER -- requirements
Module: multi_debouncer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named as below, with no other clock or reset.
REQ-002 Parameter CH, default 4, SHALL set the number of independent channels (range 1..32).
REQ-003 Parameter CNT_W, default 16, SHALL set the width of each channel's stability counter.
REQ-004 Parameter STABLE_CNT, default 1000, SHALL set the number of qualifying cycles needed to accept a level (range 1..2^CNT_W-1).
REQ-005 clk  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-006 rst  input  1  SHALL be the asynchronous active-low reset.
REQ-007 en  input  1  SHALL be the count strobe; counters advance only when en=1.
REQ-008 noisy_in  input  CH  SHALL carry the raw switch levels, one bit per channel.
REQ-009 debounce_out  output  CH  SHALL carry the accepted stable level per channel.
REQ-010 rise_pulse  output  CH  SHALL give a one-cycle pulse when debounce_out goes 0->1.
REQ-011 fall_pulse  output  CH  SHALL give a one-cycle pulse when debounce_out goes 1->0.
REQ-012 busy  output  1  SHALL be the OR over channels of "in a WAIT state".

Function
REQ-013 Each channel SHALL run an independent 4-state FSM with states LOW, WAIT_HI, HIGH and WAIT_LO, and its own CNT_W-bit counter; s_in below means the sampled input of that channel.
REQ-014 LOW: s_in=1 -> WAIT_HI with count cleared to 0; else stay in LOW.
REQ-015 WAIT_HI: s_in=0 -> LOW with count cleared (abort, no pulse); s_in=1, en=1, count==STABLE_CNT-1 -> HIGH; s_in=1, en=1 otherwise -> count+1; s_in=1, en=0 -> hold.
REQ-016 HIGH: s_in=0 -> WAIT_LO with count cleared to 0; else stay in HIGH.
REQ-017 WAIT_LO SHALL mirror WAIT_HI with polarity inverted: s_in=1 -> HIGH (abort, no pulse); completion -> LOW.
REQ-018 debounce_out SHALL be 1 exactly in HIGH and WAIT_LO.
REQ-019 rise_pulse and fall_pulse SHALL be registered and asserted in the same cycle that debounce_out first shows the new level; they SHALL never be asserted together on one channel.
REQ-020 With en held at 1 and synchronizer absent, a level held stable from cycle t SHALL appear on debounce_out at cycle t+STABLE_CNT+1.
REQ-021 A bounce SHALL restart qualification from count 0; the counter SHALL never wrap.
REQ-022 en=0 SHALL freeze counters only; abort transitions SHALL still occur.
REQ-023 Channels SHALL NOT interact; simultaneous events on several channels SHALL each be handled in the same cycle.

Reset
REQ-024 While rst=0, all channels SHALL be in LOW with count 0; debounce_out, rise_pulse, fall_pulse and busy SHALL all be 0.
REQ-025 Reset asserted mid-qualification SHALL discard progress, with no pulse on release.
REQ-026 After rst deasserts, a channel whose input is high SHALL qualify as a fresh rise.

Configuration
REQ-027 With macro DEBOUNCE_SYNC_EN defined, each noisy_in bit SHALL pass through a 2-flop synchronizer, reset to 0, before the FSM; all latencies SHALL grow by 2 cycles (REQ-020 becomes t+STABLE_CNT+3).
REQ-028 Without DEBOUNCE_SYNC_EN, s_in SHALL be noisy_in directly; the caller SHALL supply synchronous inputs.

Verification (CH=4, CNT_W=8, STABLE_CNT=4, no sync unless stated)
REQ-029 Hold noisy_in[0]=1 from cycle 10 with en=1 -> debounce_out[0]=1 and rise_pulse[0]=1 at cycle 15; pulse low at cycle 16; busy=1 for cycles 11-14.
REQ-030 On channel 1, drive 1,1,0,1,1,1,1,... -> no output during the glitch; debounce_out[1] rises 5 cycles after the final 0->1.
REQ-031 With en toggling 1,0 each cycle, a held high on channel 2 -> debounce_out[2] rises 9 cycles after the input edge.
REQ-032 Channel 3 HIGH, then input low for 2 cycles, then high again -> returns to HIGH, debounce_out[3] stays 1, no pulses; then a held low -> fall_pulse[3] after 5 cycles.
REQ-033 Assert rst during WAIT_HI on channel 0 -> all outputs 0 immediately, and no pulse after release.
REQ-034 With DEBOUNCE_SYNC_EN, repeat REQ-029 -> rise at cycle 17.
